// File: rtl/flappy_pkg.sv
// Shared types and helpers for the flappy-bird matrix game blocks.
package flappy_pkg;

    localparam int ROWS = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        GROUNDED = 2'd2,
        DEAD     = 2'd3
    } bird_state_t;

    typedef logic [2:0] row_t;

    // One-hot decode of a row index, bit 0 = bottom row.
    function automatic logic [ROWS-1:0] row_onehot(input row_t r);
        logic [ROWS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // Upward move that saturates at the top row instead of wrapping.
    function automatic row_t row_up(input row_t r, input int unsigned n);
        logic [3:0] s;
        s = {1'b0, r} + 4'(n);
        return (s > 4'd7) ? 3'd7 : s[2:0];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-N counter that flags the last count of each period.
module tick_gen #(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Tick is visible during the cycle the count sits at N-1, so the
    // consumer can act on the same edge that wraps the counter.
    assign tick = (count_q == LAST);

    // Next count: wrap after N-1, or restart when the consumer asks.
    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bird_position.sv
// Bird vertical position: flap edges lift the bird, a gravity tick drops it,
// and the result is shown as a registered one-hot row plus a ground flag.
module bird_position
    import flappy_pkg::*;
#(
    parameter int FALL_TICKS = 25000000,
    parameter int START_ROW  = 4,
    parameter int FLAP_ROWS  = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic flap,
    input  logic lossDetect,
    output logic g0,
    output logic g1,
    output logic g2,
    output logic g3,
    output logic g4,
    output logic g5,
    output logic g6,
    output logic g7,
    output logic groundOut,
    output logic playing
);

    localparam row_t START = row_t'(START_ROW);

    bird_state_t     state_q, state_d;
    row_t            pos_q, pos_d;
    logic            flap_q;
    logic [ROWS-1:0] g_q, g_d;
    logic            ground_q, ground_d;
    logic            playing_q, playing_d;

    logic rise;
    logic tick;
    logic cnt_clear;

    assign rise = flap & ~flap_q;

    tick_gen #(
        .N(FALL_TICKS)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(cnt_clear),
        .tick (tick)
    );

    // Next state and position; outputs are decoded from the next state so
    // a change taken on an edge is visible right after that edge.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        cnt_clear = 1'b1;

        case (state_q)
            IDLE: begin
                pos_d = START;
                if (rise) begin
                    state_d = FLY;
                    pos_d   = row_up(pos_q, FLAP_ROWS);
                end
            end
            FLY: begin
                cnt_clear = 1'b0;
                if (lossDetect) begin
                    state_d = DEAD;
                end else if (rise) begin
                    // A flap beats gravity and restarts the fall period.
                    pos_d     = row_up(pos_q, FLAP_ROWS);
                    cnt_clear = 1'b1;
                end else if (tick) begin
                    if (pos_q != 3'd0) begin
                        pos_d = pos_q - 3'd1;
                    end else begin
                        state_d = GROUNDED;
                    end
                end
            end
            GROUNDED: begin
                state_d = GROUNDED;
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        g_d       = (state_d == GROUNDED) ? '0 : row_onehot(pos_d);
        ground_d  = (state_d == GROUNDED);
        playing_d = (state_d == FLY);
    end

    // State, position, edge-detect and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pos_q     <= START;
            flap_q    <= 1'b0;
            g_q       <= row_onehot(START);
            ground_q  <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            flap_q    <= flap;
            g_q       <= g_d;
            ground_q  <= ground_d;
            playing_q <= playing_d;
        end
    end

    assign g0        = g_q[0];
    assign g1        = g_q[1];
    assign g2        = g_q[2];
    assign g3        = g_q[3];
    assign g4        = g_q[4];
    assign g5        = g_q[5];
    assign g6        = g_q[6];
    assign g7        = g_q[7];
    assign groundOut = ground_q;
    assign playing   = playing_q;

endmodule

// File: tb/tb_bird_position.sv
// Bench for bird_position: a hand-written vector table followed by longer
// sequences checked against a behavioural model through a scoreboard queue.
module tb_bird_position;

    localparam int FT = 4;
    localparam int SR = 4;
    localparam int FR = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flap  = 1'b0;
    logic lossDetect = 1'b0;
    logic g0, g1, g2, g3, g4, g5, g6, g7;
    logic groundOut, playing;

    bird_position #(
        .FALL_TICKS(FT),
        .START_ROW (SR),
        .FLAP_ROWS (FR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flap      (flap),
        .lossDetect(lossDetect),
        .g0(g0), .g1(g1), .g2(g2), .g3(g3),
        .g4(g4), .g5(g5), .g6(g6), .g7(g7),
        .groundOut (groundOut),
        .playing   (playing)
    );

    always #5 clock = ~clock;

    wire [7:0] g_vec = {g7, g6, g5, g4, g3, g2, g1, g0};

    typedef struct {
        logic       rst;
        logic       f;
        logic       l;
        logic [7:0] g;
        logic       gnd;
        logic       ply;
    } vec_t;

    typedef struct {
        logic [7:0] g;
        logic       gnd;
        logic       ply;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   step_no  = 0;

    // Behavioural model state: mode 0 idle, 1 flying, 2 grounded, 3 dead.
    int m_mode = 0;
    int m_row  = SR;
    int m_cnt  = 0;
    bit m_fq   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s step %0d: got %02h expected %02h", name, step_no, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic f, input logic l);
        bit rs;
        if (r) begin
            m_mode = 0; m_row = SR; m_cnt = 0; m_fq = 0;
        end else begin
            rs   = f && !m_fq;
            m_fq = f;
            if (m_mode == 0) begin
                if (rs) begin
                    m_mode = 1;
                    m_row  = (m_row + FR > 7) ? 7 : m_row + FR;
                    m_cnt  = 0;
                end
            end else if (m_mode == 1) begin
                if (l) begin
                    m_mode = 3;
                end else if (rs) begin
                    m_row = (m_row + FR > 7) ? 7 : m_row + FR;
                    m_cnt = 0;
                end else if (m_cnt == FT - 1) begin
                    m_cnt = 0;
                    if (m_row > 0) m_row = m_row - 1;
                    else m_mode = 2;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then sample
    // on the falling edge and compare with the head of the queue.
    task automatic step(input logic r, input logic f, input logic l,
                        input bit use_tab, input vec_t tv);
        exp_t e, got;
        reset = r; flap = f; lossDetect = l;
        @(posedge clock);
        model_step(r, f, l);
        if (use_tab) begin
            e.g = tv.g; e.gnd = tv.gnd; e.ply = tv.ply;
        end else begin
            e.g   = (m_mode == 2) ? 8'h00 : 8'(1 << m_row);
            e.gnd = (m_mode == 2);
            e.ply = (m_mode == 1);
        end
        sb.push_back(e);
        @(negedge clock);
        step_no++;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 8'h01, 8'h00);
        end else begin
            got = sb.pop_front();
            check("g", g_vec, got.g);
            check("groundOut", {7'd0, groundOut}, {7'd0, got.gnd});
            check("playing", {7'd0, playing}, {7'd0, got.ply});
        end
        $display("step %0d rst=%0b flap=%0b loss=%0b -> g=%02h gnd=%0b ply=%0b",
                 step_no, r, f, l, g_vec, groundOut, playing);
    endtask

    task automatic mstep(input logic r, input logic f, input logic l);
        vec_t dummy;
        dummy = '{rst: 1'b0, f: 1'b0, l: 1'b0, g: 8'h00, gnd: 1'b0, ply: 1'b0};
        step(r, f, l, 1'b0, dummy);
    endtask

    vec_t tab[15];

    initial begin
        // Pulse from idle, two gravity steps, loss freeze, reset.
        tab[0]  = '{1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        tab[1]  = '{1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 1'b1};
        tab[2]  = '{1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1};
        tab[3]  = '{1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1};
        tab[4]  = '{1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1};
        tab[6]  = '{1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1};
        tab[7]  = '{1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1};
        tab[8]  = '{1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1};
        tab[10] = '{1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0};
        tab[11] = '{1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0};
        tab[12] = '{1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
        tab[13] = '{1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 1'b0};
        tab[14] = '{1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            step(tab[i].rst, tab[i].f, tab[i].l, 1'b1, tab[i]);
        end

        // Idle after reset: bird held at the start row.
        mstep(1, 0, 0);
        for (int i = 0; i < 20; i++) mstep(0, 0, 0);
        check("idle_row", g_vec, 8'h10);

        // Held flap gives a single rise; release alone does not move.
        mstep(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            mstep(0, 1, 0);
            if (i == 0) check("held_first", g_vec, 8'h20);
        end
        for (int i = 0; i < 6; i++) mstep(0, 0, 0);

        // Repeated flaps saturate at the top row.
        mstep(1, 0, 0);
        mstep(0, 1, 0);
        mstep(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            mstep(0, 1, 0);
            mstep(0, 0, 0);
        end
        check("top_sat", g_vec, 8'h80);
        mstep(0, 0, 0); mstep(0, 0, 0);
        mstep(0, 0, 0);
        check("drop_to_6", g_vec, 8'h40);
        mstep(0, 0, 0); mstep(0, 0, 0); mstep(0, 0, 0);
        mstep(0, 1, 0);
        check("flap_beats_tick", g_vec, 8'h80);
        mstep(0, 0, 0); mstep(0, 0, 0); mstep(0, 0, 0);
        check("cnt_restart", g_vec, 8'h80);
        mstep(0, 0, 0);
        check("after_restart", g_vec, 8'h40);

        // Fall to the ground and stay there.
        mstep(1, 0, 0);
        mstep(0, 1, 0);
        for (int i = 0; i < 16; i++) mstep(0, 0, 0);
        check("row1", g_vec, 8'h02);
        for (int i = 0; i < 4; i++) mstep(0, 0, 0);
        check("row0", g_vec, 8'h01);
        for (int i = 0; i < 4; i++) mstep(0, 0, 0);
        check("grounded_g", g_vec, 8'h00);
        check("grounded_flag", {7'd0, groundOut}, 8'h01);
        for (int i = 0; i < 20; i++) mstep(0, logic'(i % 2), logic'(i % 3 == 0));
        check("grounded_hold", {g_vec[6:0], groundOut}, 8'h01);

        // Loss freezes the bird at row 3.
        mstep(1, 0, 0);
        mstep(0, 1, 0);
        for (int i = 0; i < 8; i++) mstep(0, 0, 0);
        mstep(0, 0, 1);
        for (int i = 0; i < 20; i++) mstep(0, logic'(i % 2), 0);
        check("dead_frozen", g_vec, 8'h08);

        // Reset mid-flight from row 6.
        mstep(1, 0, 0);
        mstep(0, 1, 0);
        mstep(0, 0, 0);
        mstep(0, 1, 0);
        check("row6", g_vec, 8'h40);
        mstep(1, 0, 0);
        check("midflight_reset_g", g_vec, 8'h10);
        check("midflight_reset_gnd", {7'd0, groundOut}, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
